// File: rtl/cache_ctrl_pkg.sv
// Shared types and encodings for the set-associative cache controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_ctrl_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_FILL      = 2'd2
    } state_t;

    // Data-array write source select.
    localparam logic [1:0] DSEL_MEM  = 2'b00;
    localparam logic [1:0] DSEL_CPU  = 2'b01;
    localparam logic [1:0] DSEL_NONE = 2'b11;

    // Memory address select.
    localparam logic ASEL_REQ    = 1'b0;
    localparam logic ASEL_VICTIM = 1'b1;

    // Index of the lowest set bit; 0 when the vector is empty.
    // Sized for the largest supported associativity (8 ways).
    function automatic logic [2:0] lowest_set(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/cache_control_assoc_plru.sv
// Tree pseudo-LRU state per set: victim lookup and most-recently-used update.
// Latency: lookup is combinational; an update lands at the next clock edge.
// Backpressure: none, an update strobe is always accepted.
//
// Ports:
//   clk, rst_n          clock, async active-low reset (clears every tree)
//   i_upd_en/set/way    mark i_upd_way of set i_upd_set most recently used
//   i_lkp_set           set whose PLRU victim is reported on o_victim
module plru_tree #(
    parameter int WAYS    = 4,
    parameter int S_INDEX = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_upd_en,
    input  logic [S_INDEX-1:0]       i_upd_set,
    input  logic [$clog2(WAYS)-1:0]  i_upd_way,
    input  logic [S_INDEX-1:0]       i_lkp_set,
    output logic [$clog2(WAYS)-1:0]  o_victim
);

    localparam int LVL   = $clog2(WAYS);
    localparam int NSETS = 2 ** S_INDEX;

    // Heap-ordered tree: node n has children 2n+1 / 2n+2; node bit 1
    // means the victim lies in the upper half below that node.
    logic [WAYS-2:0] r_bits [NSETS];
    logic [WAYS-2:0] w_next;
    logic [WAYS-2:0] w_set_bits;
    logic [LVL-1:0]  w_vic;

    // Nodes on the accessed way's path are set to point at the other half.
    always_comb begin
        w_next = r_bits[i_upd_set];
        for (int l = 0; l < LVL; l++) begin
            for (int k = 0; k < (1 << l); k++) begin
                if (int'(i_upd_way >> (LVL - l)) == k)
                    w_next[(1 << l) - 1 + k] = ~i_upd_way[LVL-1-l];
            end
        end
    end

    // Walk from the root, building the victim index MSB first; the bits
    // already resolved select which node to consult at the next level.
    assign w_set_bits = r_bits[i_lkp_set];
    always_comb begin
        w_vic = '0;
        for (int l = 0; l < LVL; l++) begin
            for (int k = 0; k < (1 << l); k++) begin
                if (int'(w_vic >> (LVL - l)) == k)
                    w_vic[LVL-1-l] = w_set_bits[(1 << l) - 1 + k];
            end
        end
    end
    assign o_victim = w_vic;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NSETS; s++) r_bits[s] <= '0;
        end else if (i_upd_en) begin
            r_bits[i_upd_set] <= w_next;
        end
    end

endmodule

// File: rtl/cache_control_assoc.sv
// Set-associative cache controller: hit handling, victim choice, writeback and fill.
// Latency: hit 0 cycles; clean miss fill+1; dirty miss writeback+fill+1.
// Backpressure: CPU request held (no mem_resp) until the line is resident; memory paced by pmem_resp.
//
// Ports: clk/rst_n; CPU side mem_read, mem_write, mem_index, mem_resp;
// memory side pmem_read, pmem_write, pmem_resp; array status hit_vec,
// valid_vec, dirty_vec; datapath control way_sel, tag_load, valid_load,
// dirty_load, dirty_in, data_sel, addr_sel.
// Optional CACHE_PERF_CTR_EN adds hit_count / miss_count outputs.
module cache_control_assoc
    import cache_ctrl_pkg::*;
#(
    parameter int WAYS    = 4,
    parameter int S_INDEX = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic [S_INDEX-1:0]       mem_index,
    output logic                     mem_resp,
    output logic                     pmem_read,
    output logic                     pmem_write,
    input  logic                     pmem_resp,
    input  logic [WAYS-1:0]          hit_vec,
    input  logic [WAYS-1:0]          valid_vec,
    input  logic [WAYS-1:0]          dirty_vec,
    output logic [$clog2(WAYS)-1:0]  way_sel,
    output logic                     tag_load,
    output logic                     valid_load,
    output logic                     dirty_load,
    output logic                     dirty_in,
    output logic [1:0]               data_sel,
    output logic                     addr_sel
`ifdef CACHE_PERF_CTR_EN
    ,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
`endif
);

    localparam int WL = $clog2(WAYS);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [WL-1:0]  r_victim;

    logic           w_req;
    logic           w_is_write;
    logic           w_hit;
    logic [WL-1:0]  w_hit_way;
    logic [WL-1:0]  w_inv_way;
    logic [WL-1:0]  w_plru_way;
    logic [WL-1:0]  w_miss_victim;
    logic           w_victim_dirty;
    logic           w_plru_upd;
    logic           w_miss_start;

    // Requests are ignored while reset is held so no array strobe can fire.
    assign w_req      = (mem_read | mem_write) & rst_n;
    assign w_is_write = mem_write;
    assign w_hit      = |hit_vec;
    assign w_hit_way  = WL'(lowest_set(8'(hit_vec)));
    assign w_inv_way  = WL'(lowest_set(8'(~valid_vec)));

    // Empty ways are filled first; PLRU only decides among a full set.
    assign w_miss_victim  = (&valid_vec) ? w_plru_way : w_inv_way;
    assign w_victim_dirty = dirty_vec[w_miss_victim];

    plru_tree #(
        .WAYS    (WAYS),
        .S_INDEX (S_INDEX)
    ) u_plru (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_upd_en  (w_plru_upd),
        .i_upd_set (mem_index),
        .i_upd_way (w_hit_way),
        .i_lkp_set (mem_index),
        .o_victim  (w_plru_way)
    );

    always_comb begin
        w_state_nxt  = r_state;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        tag_load     = 1'b0;
        valid_load   = 1'b0;
        dirty_load   = 1'b0;
        dirty_in     = 1'b0;
        data_sel     = DSEL_NONE;
        addr_sel     = ASEL_REQ;
        way_sel      = w_hit_way;
        w_plru_upd   = 1'b0;
        w_miss_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (w_hit) begin
                        mem_resp   = 1'b1;
                        w_plru_upd = 1'b1;
                        if (w_is_write) begin
                            dirty_load = 1'b1;
                            dirty_in   = 1'b1;
                            data_sel   = DSEL_CPU;
                        end
                    end else begin
                        w_miss_start = 1'b1;
                        w_state_nxt  = w_victim_dirty ? ST_WRITEBACK : ST_FILL;
                    end
                end
            end
            ST_WRITEBACK: begin
                pmem_write = 1'b1;
                addr_sel   = ASEL_VICTIM;
                way_sel    = r_victim;
                if (pmem_resp) w_state_nxt = ST_FILL;
            end
            ST_FILL: begin
                pmem_read = 1'b1;
                data_sel  = DSEL_MEM;
                way_sel   = r_victim;
                if (pmem_resp) begin
                    tag_load    = 1'b1;
                    valid_load  = 1'b1;
                    dirty_load  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_victim <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_miss_start) r_victim <= w_miss_victim;
        end
    end

`ifdef CACHE_PERF_CTR_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (mem_resp)     r_hit_count  <= r_hit_count + 32'd1;
            if (w_miss_start) r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_cache_control_assoc.sv
// Directed and randomized check of cache_control_assoc against a tree-PLRU model.
// Latency: n/a (testbench).
// Backpressure: the bench plays memory and answers pmem requests after chosen delays.
module tb_cache_control_assoc;

    localparam int WAYS    = 4;
    localparam int S_INDEX = 3;
    localparam int NSETS   = 1 << S_INDEX;
    localparam int WL      = $clog2(WAYS);

    logic               clk;
    logic               rst_n;
    logic               mem_read, mem_write;
    logic [S_INDEX-1:0] mem_index;
    logic               mem_resp, pmem_read, pmem_write, pmem_resp;
    logic [WAYS-1:0]    hit_vec, valid_vec, dirty_vec;
    logic [WL-1:0]      way_sel;
    logic               tag_load, valid_load, dirty_load, dirty_in;
    logic [1:0]         data_sel;
    logic               addr_sel;
`ifdef CACHE_PERF_CTR_EN
    logic [31:0]        hit_count, miss_count;
`endif

    int n_checks = 0;
    int n_err    = 0;

    // Reference PLRU: one bit per tree node, node n covering a contiguous
    // range of ways; a set bit sends the victim search to the upper half.
    bit m_tree [NSETS][WAYS];

    cache_control_assoc #(.WAYS(WAYS), .S_INDEX(S_INDEX)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_index  (mem_index),
        .mem_resp   (mem_resp),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .pmem_resp  (pmem_resp),
        .hit_vec    (hit_vec),
        .valid_vec  (valid_vec),
        .dirty_vec  (dirty_vec),
        .way_sel    (way_sel),
        .tag_load   (tag_load),
        .valid_load (valid_load),
        .dirty_load (dirty_load),
        .dirty_in   (dirty_in),
        .data_sel   (data_sel),
        .addr_sel   (addr_sel)
`ifdef CACHE_PERF_CTR_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int lowest(input logic [WAYS-1:0] v);
        int r;
        r = -1;
        for (int i = WAYS - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    function automatic int m_pick(input int s);
        int lo, n, node;
        lo = 0; n = WAYS; node = 0;
        while (n > 1) begin
            if (m_tree[s][node]) begin
                lo   = lo + n / 2;
                node = 2 * node + 2;
            end else begin
                node = 2 * node + 1;
            end
            n = n / 2;
        end
        return lo;
    endfunction

    task automatic m_touch(input int s, input int w);
        int lo, n, node;
        lo = 0; n = WAYS; node = 0;
        while (n > 1) begin
            if (w >= lo + n / 2) begin
                m_tree[s][node] = 1'b0;
                lo   = lo + n / 2;
                node = 2 * node + 2;
            end else begin
                m_tree[s][node] = 1'b1;
                node = 2 * node + 1;
            end
            n = n / 2;
        end
    endtask

    task automatic m_clear();
        for (int s = 0; s < NSETS; s++)
            for (int n = 0; n < WAYS; n++) m_tree[s][n] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; pmem_resp = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        hit_vec = '0; valid_vec = '0; dirty_vec = '0; mem_index = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
        m_clear();
    endtask

    // One CPU request from IDLE to completion. On a miss the bench plays
    // memory with the given delays and then reports the line resident.
    // With drop set the request is withdrawn during the transfer.
    task automatic xact(input int s, input bit rd, input bit wr,
                        input logic [WAYS-1:0] hv, input logic [WAYS-1:0] vv,
                        input logic [WAYS-1:0] dv, input int wb_lat,
                        input int fill_lat, input bit drop, output int way_obs);
        int vic, hw;
        logic [WAYS-1:0] oh;
        mem_index = S_INDEX'(s); mem_read = rd; mem_write = wr;
        hit_vec = hv; valid_vec = vv; dirty_vec = dv; pmem_resp = 1'b0;
        @(negedge clk);
        way_obs = int'(way_sel);
        if (hv != '0) begin
            hw = lowest(hv);
            chk("hit_resp", mem_resp, 1);
            chk("hit_way", way_sel, hw);
            chk("hit_dload", dirty_load, wr);
            chk("hit_din", dirty_in, wr);
            chk("hit_dsel", data_sel, wr ? 2'b01 : 2'b11);
            chk("hit_quiet", {pmem_read, pmem_write, tag_load, valid_load, addr_sel}, 0);
            m_touch(s, hw);
            cyc();
        end else begin
            vic = (&vv) ? m_pick(s) : lowest(~vv);
            chk("miss_idle", {mem_resp, pmem_read, pmem_write, tag_load, valid_load, dirty_load}, 0);
            cyc();
            if (drop) begin
                mem_read = 1'b0; mem_write = 1'b0;
            end
            if (dv[vic]) begin
                for (int i = 0; i <= wb_lat; i++) begin
                    pmem_resp = (i == wb_lat);
                    @(negedge clk);
                    chk("wb_write", pmem_write, 1);
                    chk("wb_asel", addr_sel, 1);
                    chk("wb_way", way_sel, vic);
                    chk("wb_quiet", {mem_resp, pmem_read, tag_load, valid_load, dirty_load}, 0);
                    cyc();
                end
            end
            for (int i = 0; i <= fill_lat; i++) begin
                pmem_resp = (i == fill_lat);
                @(negedge clk);
                chk("fill_read", pmem_read, 1);
                chk("fill_dsel", data_sel, 2'b00);
                chk("fill_way", way_sel, vic);
                chk("fill_quiet", {mem_resp, pmem_write, addr_sel, dirty_in}, 0);
                chk("fill_load", {tag_load, valid_load, dirty_load}, (i == fill_lat) ? 3'b111 : 3'b000);
                if (i == fill_lat) way_obs = int'(way_sel);
                cyc();
            end
            pmem_resp = 1'b0;
            oh = '0;
            oh[vic] = 1'b1;
            hit_vec = oh; valid_vec = vv | oh; dirty_vec = dv & ~oh;
            @(negedge clk);
            if (drop) begin
                chk("drop_noresp", {mem_resp, pmem_read, pmem_write}, 0);
            end else begin
                chk("refill_resp", mem_resp, 1);
                chk("refill_way", way_sel, vic);
                chk("refill_dload", dirty_load, wr);
                m_touch(s, vic);
            end
            cyc();
        end
        mem_read = 1'b0; mem_write = 1'b0; hit_vec = '0;
    endtask

    initial begin
        int obs;
        int s;
        logic [WAYS-1:0] vv, dv, hv;
        bit rd, wr;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_quiet", {mem_resp, pmem_read, pmem_write, tag_load, valid_load, dirty_load, dirty_in, addr_sel}, 0);
        chk("rst_dsel", data_sel, 2'b11);
        chk("rst_way", way_sel, 0);
        cyc();

        // Cold read miss on set 2, memory answers after 5 cycles
        xact(2, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 5, 0, obs);
        chk("s1_victim", obs, 0);

        // Write hit on way 2
        xact(2, 0, 1, 4'b0100, 4'b0101, 4'b0000, 0, 0, 0, obs);
        chk("s2_way", obs, 2);

        // Full set: touch 0..3, then a dirty miss must evict way 0
        for (int w = 0; w < WAYS; w++) begin
            hv = '0;
            hv[w] = 1'b1;
            xact(5, 1, 0, hv, 4'b1111, 4'b0000, 0, 0, 0, obs);
        end
        xact(5, 1, 0, 4'b0000, 4'b1111, 4'b0001, 3, 2, 0, obs);
        chk("s3_victim", obs, 0);
        xact(5, 1, 0, 4'b0000, 4'b1111, 4'b0000, 0, 1, 0, obs);
        chk("s3_victim2", obs, 2);

        // Read and write together behave as a write
        xact(5, 1, 1, 4'b0010, 4'b1111, 4'b0000, 0, 0, 0, obs);
        chk("s4_way", obs, 1);

        // Request withdrawn during the transfer: line completes, no response
        xact(6, 1, 0, 4'b0000, 4'b0011, 4'b0000, 0, 2, 1, obs);
        chk("drop_victim", obs, 2);

        // Reset asserted during FILL
        mem_index = 3'd1; mem_read = 1'b1; hit_vec = '0; valid_vec = '0; dirty_vec = '0;
        @(negedge clk);
        cyc();
        @(negedge clk);
        chk("s5_in_fill", pmem_read, 1);
        cyc();
        pmem_resp = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("s5_drop", {pmem_read, pmem_write, tag_load, valid_load, dirty_load, mem_resp}, 0);
        cyc();
        chk("s5_held", {pmem_read, pmem_write, tag_load}, 0);
        rst_n = 1'b1;
        pmem_resp = 1'b0;
        m_clear();
        @(negedge clk);
        chk("s5_idle", {pmem_read, pmem_write, mem_resp}, 0);
        mem_read = 1'b0;
        cyc();
        // PLRU cleared by reset: a full-set miss on set 5 evicts way 0 again
        xact(5, 1, 0, 4'b0000, 4'b1111, 4'b0000, 0, 0, 1, obs);
        chk("s5_plru_clr", obs, 0);

`ifdef CACHE_PERF_CTR_EN
        do_reset();
        xact(0, 1, 0, 4'b0001, 4'b0001, 4'b0000, 0, 0, 0, obs);
        xact(1, 0, 1, 4'b0010, 4'b0010, 4'b0000, 0, 0, 0, obs);
        xact(0, 1, 0, 4'b0001, 4'b0001, 4'b0000, 0, 0, 0, obs);
        xact(3, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 1, obs);
        xact(4, 1, 0, 4'b0000, 4'b1111, 4'b0000, 0, 0, 1, obs);
        chk("perf_hits", hit_count, 3);
        chk("perf_misses", miss_count, 2);
        dut.r_hit_count = 32'hFFFF_FFFF;
        xact(0, 1, 0, 4'b0001, 4'b0001, 4'b0000, 0, 0, 0, obs);
        chk("perf_wrap", hit_count, 0);
        chk("perf_misses2", miss_count, 2);
`endif

        // Randomized traffic against the reference model
        for (int t = 0; t < 60; t++) begin
            s  = int'($urandom_range(0, NSETS - 1));
            vv = WAYS'($urandom);
            if ($urandom_range(0, 1) == 1) vv = '1;
            dv = WAYS'($urandom) & vv;
            hv = '0;
            if ($urandom_range(0, 1) == 1 && vv != '0) begin
                hv = vv & WAYS'($urandom);
                if (hv == '0) hv = vv;
            end
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if (!rd && !wr) rd = 1'b1;
            xact(s, rd, wr, hv, vv, dv, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), obs);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/cache_control_assoc.md
CACHE_CONTROL_ASSOC -- requirements
Module: cache_control_assoc

Interface
REQ-001 SHALL have parameter WAYS, default 4, number of ways; power of two, 2 to 8.
REQ-002 SHALL have parameter S_INDEX, default 3, set-index width; 2**S_INDEX sets.
REQ-003 SHALL have the following ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_read  in  1  CPU read request.
- mem_write  in  1  CPU write request.
- mem_index  in  S_INDEX  set index of the request.
- mem_resp  out  1  CPU request done.
- pmem_read  out  1  memory line read.
- pmem_write  out  1  memory line write.
- pmem_resp  in  1  memory transfer done.
- hit_vec  in  WAYS  per-way valid and tag match.
- valid_vec  in  WAYS  valid bits of the indexed set.
- dirty_vec  in  WAYS  dirty bits of the indexed set.
- way_sel  out  $clog2(WAYS)  way addressed by the datapath.
- tag_load, valid_load, dirty_load, dirty_in  out  1 each  array load strobes and dirty value.
- data_sel  out  2  data-array write source: 00 memory fill, 01 CPU write, 11 none.
- addr_sel  out  1  pmem address: 0 = request tag, 1 = victim tag.

Function
REQ-004 SHALL implement states IDLE, WRITEBACK and FILL.
REQ-005 Defaults in every state: all strobes 0, data_sel=11, addr_sel=0, way_sel=hit way.
REQ-006 When mem_read and mem_write are asserted together, the request SHALL be treated as a write.
REQ-007 IDLE hit (request and |hit_vec):
- mem_resp=1 in the same cycle.
- way_sel = lowest set bit of hit_vec.
- On a write: dirty_load=1, dirty_in=1, data_sel=01.
- The PLRU state of mem_index SHALL be updated at the next edge to mark that way most recently used.
REQ-008 IDLE miss: the victim SHALL be the lowest-index way with valid_vec=0; if all ways are valid, the victim SHALL be the PLRU way; the victim SHALL be latched at the transition edge.
REQ-009 IDLE miss with a dirty victim SHALL go to WRITEBACK; a clean victim SHALL go to FILL; there is no pmem activity in the IDLE cycle.
REQ-010 WRITEBACK SHALL drive pmem_write=1, addr_sel=1 and way_sel=victim, and SHALL go to FILL on pmem_resp.
REQ-011 FILL SHALL drive pmem_read=1, data_sel=00 and way_sel=victim.
REQ-012 FILL with pmem_resp SHALL pulse tag_load, valid_load and dirty_load with dirty_in=0, then return to IDLE; the request then hits on the following cycle.
REQ-013 Latency:
- hit: 0 cycles.
- clean miss: fill cycles + 1.
- dirty miss: writeback + fill + 1.
REQ-014 A request deasserted during WRITEBACK or FILL SHALL NOT abort the transfer; the line completes, and no mem_resp is issued until a request is present in IDLE.
REQ-015 The PLRU SHALL be a tree of WAYS-1 bits per set; each access flips the bits along its path to point away from the accessed way.

Reset
REQ-016 rst_n low SHALL asynchronously force state=IDLE, clear the latched victim to 0, and clear all PLRU bits to 0.
REQ-017 Reset mid-miss SHALL drop pmem_read and pmem_write in the same cycle with no array loads; an in-flight memory transfer is discarded.

Configuration
REQ-018 With CACHE_PERF_CTR_EN defined:
- output ports hit_count[31:0] and miss_count[31:0] SHALL exist.
- hit_count increments on each IDLE hit with mem_resp; miss_count increments on each IDLE to WRITEBACK or FILL transition.
- Both counters wrap at 2**32, and reset clears them to 0.
REQ-019 Without CACHE_PERF_CTR_EN, these ports and their registers SHALL be absent.

Structure
REQ-020 Package cache_ctrl_pkg SHALL hold the state enum, the data_sel encodings (DSEL_MEM, DSEL_CPU, DSEL_NONE) and the addr_sel encodings.
REQ-021 Sub-module plru_tree SHALL be parameterised by WAYS and S_INDEX, provide update and victim lookup, and own the per-set PLRU storage.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset, then read to set 2 with hit_vec=0, valid_vec=0: victim way 0; FILL; pmem_resp after 5 cycles gives tag/valid load on way 0; mem_resp one cycle after FILL exit.
- Write hit with hit_vec=0100: mem_resp, dirty_load, dirty_in=1, data_sel=01 and way_sel=2, all in the same cycle.
- Set full: access ways 0, 1, 2, 3 in order, then miss: victim way 0; dirty_vec=0001 gives WRITEBACK with addr_sel=1 and pmem_write, then FILL.
- mem_read and mem_write both high with a hit: write behaviour (dirty_load=1).
- rst_n asserted low during FILL: pmem_read=0 immediately, state IDLE, no tag_load.
- With CACHE_PERF_CTR_EN: 3 hits and 2 misses give hit_count=3, miss_count=2; a preloaded 0xFFFFFFFF plus one hit gives 0.
